// File: rtl/md_unit_if.sv
// Issue/result bundle between the E-stage and the multiply/divide unit.
// master drives the md-class instruction; slave returns busy and HI/LO.
interface md_unit_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO; MULT/DIV run a fixed latency, MTHI/MTLO one cycle.
// Optional feature: define MD_MADD_EN to decode MADD/MADDU/MSUB (ops 7-9).
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    md_unit_if.slave  bus
);
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
`endif

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_q, lo_q;
    logic [31:0]      pend_hi, pend_lo;
    logic             pend_wr;

    logic             launch;
    logic [CNT_W-1:0] n_cyc;
    logic [31:0]      res_hi, res_lo;
    logic             res_wr;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        a_mag, b_mag, b_div, bu_div;
    logic [31:0]        uq, ur, sq, sr, dq, dr;

    // Signed divide via magnitudes: 0x80000000 / -1 wraps to 0x80000000 naturally.
    always_comb begin
        prod_s = $signed(bus.a) * $signed(bus.b);
        prod_u = {32'd0, bus.a} * {32'd0, bus.b};
        a_mag  = bus.a[31] ? (32'd0 - bus.a) : bus.a;
        b_mag  = bus.b[31] ? (32'd0 - bus.b) : bus.b;
        b_div  = (b_mag == '0) ? 32'd1 : b_mag;
        bu_div = (bus.b == '0) ? 32'd1 : bus.b;
        uq     = a_mag / b_div;
        ur     = a_mag % b_div;
        sq     = (bus.a[31] ^ bus.b[31]) ? (32'd0 - uq) : uq;
        sr     = bus.a[31] ? (32'd0 - ur) : ur;
        dq     = bus.a / bu_div;
        dr     = bus.a % bu_div;
    end

    always_comb begin
        launch = 1'b0;
        n_cyc  = '0;
        res_hi = hi_q;
        res_lo = lo_q;
        res_wr = 1'b0;
        if (state == S_IDLE && bus.start) begin
            case (bus.op)
                OP_MULT: begin
                    launch = 1'b1;
                    n_cyc  = CNT_W'(MULT_CYCLES);
                    {res_hi, res_lo} = prod_s;
                    res_wr = 1'b1;
                end
                OP_MULTU: begin
                    launch = 1'b1;
                    n_cyc  = CNT_W'(MULT_CYCLES);
                    {res_hi, res_lo} = prod_u;
                    res_wr = 1'b1;
                end
                OP_DIV: begin
                    launch = 1'b1;
                    n_cyc  = CNT_W'(DIV_CYCLES);
                    res_hi = sr;
                    res_lo = sq;
                    res_wr = (bus.b != '0);
                end
                OP_DIVU: begin
                    launch = 1'b1;
                    n_cyc  = CNT_W'(DIV_CYCLES);
                    res_hi = dr;
                    res_lo = dq;
                    res_wr = (bus.b != '0);
                end
`ifdef MD_MADD_EN
                OP_MADD: begin
                    launch = 1'b1;
                    n_cyc  = CNT_W'(MULT_CYCLES);
                    {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
                    res_wr = 1'b1;
                end
                OP_MADDU: begin
                    launch = 1'b1;
                    n_cyc  = CNT_W'(MULT_CYCLES);
                    {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
                    res_wr = 1'b1;
                end
                OP_MSUB: begin
                    launch = 1'b1;
                    n_cyc  = CNT_W'(MULT_CYCLES);
                    {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
                    res_wr = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        pend_hi <= res_hi;
                        pend_lo <= res_lo;
                        pend_wr <= res_wr;
                        cnt     <= n_cyc;
                        state   <= S_RUN;
                    end else if (bus.start && bus.op == OP_MTHI) begin
                        hi_q <= bus.a;
                    end else if (bus.start && bus.op == OP_MTLO) begin
                        lo_q <= bus.a;
                    end
                end
                default: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        // Divide-by-zero still burns its latency but leaves HI/LO alone.
                        if (pend_wr) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = (state == S_RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
